// File: rtl/crc8_chk_calc_pkg.sv
// Shared CRC-8 constants and the byte-fold function.
// The core and the accumulator both use this function, and checkers can reuse it.
package crc8_chk_calc_pkg;

  typedef logic [7:0] crc8_t;

  localparam crc8_t CRC8_POLY = 8'h07;
  localparam crc8_t CRC8_INIT = 8'h00;

  // MSB-first fold of one byte; no reflection, no final XOR (CRC-8/SMBUS).
  function automatic crc8_t crc8_byte(input crc8_t crc, input crc8_t data,
                                      input crc8_t poly = CRC8_POLY);
    crc8_t v;
    v = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      v = v[7] ? ((v << 1) ^ poly) : (v << 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/crc8_chk_calc_byte_comb.sv
// Pure combinational CRC-8 core: folds one data byte into a running CRC.
module crc8_byte_comb
  import crc8_chk_calc_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY
) (
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  always_comb begin
    crc_out = crc8_byte(crc_in, data_in, POLY);
  end

endmodule

// File: rtl/crc8_chk_calc.sv
// Byte-wise CRC-8 engine: a free combinational core plus an optional
// accumulator register with clear, enable and compare against data_in.
module crc8_chk_calc
  import crc8_chk_calc_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY,
  parameter logic [7:0] INIT = CRC8_INIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out,
  input  logic       acc_clr,
  input  logic       acc_en,
  output logic [7:0] acc_crc,
  output logic       acc_match
);

  logic [7:0] acc_crc_q;
  logic [7:0] acc_crc_d;
  logic [7:0] acc_fold;

  crc8_byte_comb #(.POLY(POLY)) u_core (
    .crc_in  (crc_in),
    .data_in (data_in),
    .crc_out (crc_out)
  );

  crc8_byte_comb #(.POLY(POLY)) u_acc_core (
    .crc_in  (acc_crc_q),
    .data_in (data_in),
    .crc_out (acc_fold)
  );

  // Clear beats enable: a byte presented alongside acc_clr is dropped.
  always_comb begin
    acc_crc_d = acc_crc_q;
    if (acc_clr) begin
      acc_crc_d = INIT;
    end else if (acc_en) begin
      acc_crc_d = acc_fold;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_crc_q <= INIT;
    end else begin
      acc_crc_q <= acc_crc_d;
    end
  end

  assign acc_crc   = acc_crc_q;
  assign acc_match = (acc_crc_q == data_in);

endmodule

// File: tb/tb_crc8_chk_calc.sv
// Scoreboard bench for crc8_chk_calc: the stimulus pushes expectations and a
// negedge monitor pops them and compares them against the DUT.
module tb_crc8_chk_calc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] crc_in = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic [7:0] crc_out;
  logic       acc_clr = 1'b0;
  logic       acc_en = 1'b0;
  logic [7:0] acc_crc;
  logic       acc_match;

  always #5 clk = ~clk;

  crc8_chk_calc #(.POLY(8'h07), .INIT(8'h00)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .crc_in    (crc_in),
    .data_in   (data_in),
    .crc_out   (crc_out),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .acc_crc   (acc_crc),
    .acc_match (acc_match)
  );

  typedef struct packed {
    logic [7:0] tag;
    logic       chk_acc;
    logic [7:0] crc;
    logic [7:0] acc;
    logic       match;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] m_acc = 8'h00;
  logic       m_valid = 1'b0;

  // Remainder of (crc^data)*x^8 modulo x^8+x^2+x+1, by long division.
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic [15:0] g;
    r = {c ^ d, 8'h00};
    g = 16'h0107;
    for (int b = 15; b >= 8; b--) begin
      if (r[b]) r = r ^ (g << (b - 8));
    end
    return r[7:0];
  endfunction

  function automatic string tag_name(input logic [7:0] t);
    case (t)
      8'd0:    return "reset";
      8'd1:    return "idle";
      8'd2:    return "single";
      8'd3:    return "chain";
      8'd4:    return "match";
      8'd5:    return "clear";
      8'd6:    return "midrst";
      default: return "sweep";
    endcase
  endfunction

  // kmask: bit0 crc_out, bit1 acc_crc, bit2 acc_match take the given constants.
  task automatic step(input logic r, input logic c, input logic e,
                      input logic [7:0] ci, input logic [7:0] di,
                      input logic [7:0] tag, input logic [2:0] kmask,
                      input logic [7:0] kcrc, input logic [7:0] kacc,
                      input logic kmatch);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = r; acc_clr = c; acc_en = e; crc_in = ci; data_in = di;
    x.tag     = tag;
    x.chk_acc = m_valid | kmask[1];
    x.crc     = kmask[0] ? kcrc : ref_crc(ci, di);
    x.acc     = kmask[1] ? kacc : m_acc;
    x.match   = kmask[2] ? kmatch : (m_acc == di);
    q.push_back(x);
    if (!r) begin
      m_acc = 8'h00; m_valid = 1'b1;
    end else if (c) begin
      m_acc = 8'h00; m_valid = 1'b1;
    end else if (e) begin
      m_acc = ref_crc(m_acc, di);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      total++;
      if (crc_out !== x.crc) begin
        bad++;
        $display("FAIL crc_out/%s: got %h want %h (crc_in=%h data_in=%h)",
                 tag_name(x.tag), crc_out, x.crc, crc_in, data_in);
      end
      if (x.chk_acc) begin
        total += 2;
        if (acc_crc !== x.acc) begin
          bad++;
          $display("FAIL acc_crc/%s: got %h want %h", tag_name(x.tag), acc_crc, x.acc);
        end
        if (acc_match !== x.match) begin
          bad++;
          $display("FAIL acc_match/%s: got %b want %b (data_in=%h)",
                   tag_name(x.tag), acc_match, x.match, data_in);
        end
      end
    end
  end

  initial begin
    logic [7:0] msg [9];
    logic [7:0] chain;
    logic [15:0] pair;
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);

    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'd0, 3'b001, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd1, 3'b111, 8'h00, 8'h00, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 8'd2, 3'b011, 8'h07, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 8'd2, 3'b011, 8'h89, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'd2, 3'b011, 8'hF3, 8'h00, 1'b0);

    // "123456789" through both the core (chained by the model) and the accumulator.
    chain = 8'h00;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) step(1'b1, 1'b0, 1'b1, chain, msg[i], 8'd3, 3'b001, 8'hF4, 8'h00, 1'b0);
      else        step(1'b1, 1'b0, 1'b1, chain, msg[i], 8'd3, 3'b000, 8'h00, 8'h00, 1'b0);
      chain = ref_crc(chain, msg[i]);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'hF4, 8'd4, 3'b110, 8'h00, 8'hF4, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'hF5, 8'd4, 3'b110, 8'h00, 8'hF4, 1'b0);

    step(1'b1, 1'b1, 1'b1, 8'h00, 8'h01, 8'd5, 3'b010, 8'h00, 8'hF4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd5, 3'b110, 8'h00, 8'h00, 1'b1);

    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'd6, 3'b000, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'($urandom), 8'd6, 3'b000, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h00, 8'h01, 8'd6, 3'b010, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd6, 3'b010, 8'h00, 8'h07, 1'b0);

    // Exhaustive core sweep while the accumulator is randomly busy.
    for (int i = 0; i < 65536; i++) begin
      pair = 16'(i);
      step(($urandom_range(15) != 0), ($urandom_range(7) == 0), 1'($urandom),
           pair[15:8], pair[7:0], 8'd7, 3'b000, 8'h00, 8'h00, 1'b0);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc8_chk_calc.md
# crc8_chk_calc

Byte-wise CRC-8 engine for the packet-processing checkers and parser datapath. A combinational core folds one data byte into a running CRC-8 value (polynomial 0x07, MSB-first). It serves callers that keep their own mid-result register. An optional built-in accumulator register, with clear, enable and a compare flag, serves callers that want the running CRC held inside the block.

## Interface
Parameters:
- POLY, 8'h07, generator polynomial without the x^8 term (x^8+x^2+x+1).
- INIT, 8'h00, accumulator value after reset or clear.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low (0 = reset), sampled on rising edge of clk.
- crc_in  in  8  running CRC entering the combinational core.
- data_in  in  8  data byte to fold in; shared by the core and the accumulator.
- crc_out  out  8  combinational result crc8(crc_in, data_in).
- acc_clr  in  1  synchronous clear of the accumulator to INIT.
- acc_en  in  1  fold data_in into the accumulator this cycle.
- acc_crc  out  8  registered accumulator value.
- acc_match  out  1  combinational, (acc_crc == data_in); used to compare against an extracted CRC byte.

## Operation
- Core, purely combinational:
  - start with v = crc_in ^ data_in;
  - repeat 8 times: if v[7] then v = (v<<1) ^ POLY, else v = v<<1, keeping 8 bits;
  - crc_out = v.
- No input or output reflection and no final XOR; this matches CRC-8/SMBUS.
- crc_out depends only on crc_in and data_in. It is independent of clk, reset and the accumulator. Callers may register it in the same cycle.
- Accumulator, next-state priority:
  - reset low: acc_crc <= INIT;
  - else acc_clr: acc_crc <= INIT;
  - else acc_en: acc_crc <= crc8(acc_crc, data_in) using the same function as the core;
  - else hold.
- acc_clr and acc_en both high: the clear wins and the byte is dropped.
- A multi-byte CRC is computed by chaining: crc_in for byte k+1 = crc_out of byte k, starting from 8'h00.

## Timing
- crc_out and acc_match: zero-cycle latency. No internal state sits on the crc_out path.
- acc_crc: updates one cycle after acc_en is sampled high. A byte presented in cycle n is reflected in acc_crc in cycle n+1.
- Reset values: acc_crc = INIT (8'h00). acc_match follows its equation (1 when data_in == INIT). crc_out is unaffected by reset.
- Reset asserted mid-stream: the accumulator returns to INIT on the next edge regardless of acc_en or acc_clr. There is no partial state.
- Back-to-back acc_en for any number of cycles is legal, one byte per cycle. There is no backpressure and no handshake.
- Inputs must be stable before the rising edge. The design is fully synchronous with no clock-domain crossings.

## Structure
- A shared package holds CRC8_POLY = 8'h07 and CRC8_INIT = 8'h00. It also holds function crc8_byte(crc, data), which is the single source of truth for both the core and the accumulator and is reusable by checkers.
- One sub-module, crc8_byte_comb, is natural: the pure combinational core wrapping the function. It is instantiated once for crc_out and once for the accumulator next-state.
- The top level holds only the accumulator register and the compare.

## Test plan
- Core single byte, crc_in=00: data 01 -> crc_out 07; data 80 -> 89; data FF -> F3; data 00 -> 00.
- Core chaining: feed ASCII "123456789" (31..39), each crc_out fed back as crc_in, starting at 00 -> final 0xF4.
- Accumulator:
  - reset low one cycle -> acc_crc 00;
  - acc_en with data 31..39 over 9 consecutive cycles -> acc_crc F4 the cycle after the last byte;
  - then data_in=F4 -> acc_match 1; data_in=F5 -> acc_match 0.
- Clear priority: acc_crc=F4, then drive acc_clr=1 and acc_en=1 with data 01 -> acc_crc 00 next cycle, not 07.
- Reset mid-stream: after 4 enabled bytes, pull reset low while acc_en stays 1 -> acc_crc 00 next cycle. Release reset and feed data 01 -> 07.
- Independence: with the accumulator busy, sweep crc_in and data_in exhaustively (65536 pairs). Compare crc_out against the reference function; it must never depend on acc_* inputs or on reset.
